// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the burst SPI master.
// FSM state encoding, instruction field offsets, mode-0 idle levels.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_DATA,
    ST_HOLD
  } state_e;

  // Field offsets counted down from the instruction MSB:
  // R/nW at [CMD_W-1], W1:W0 at [CMD_W-2 -: 2].
  localparam int RNW_OFS  = 1;
  localparam int WCNT_OFS = 2;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

  // W1:W0 + 1, clamped to the configured burst depth.
  function automatic int nbytes_f(
    input logic [1:0] w,
    input int         max_b
  );
    int n;
    n = int'(w) + 1;
    if (n > max_b) n = max_b;
    return n;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SCLK divider, CLK_DIV cycles per half-period.
// Ports: sys_clk_i, rst_n_i, en_i in; sclk_o level, rise_o/fall_o ticks out.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap   = en_i && (div_cnt == DW'(CLK_DIV - 1));
  // Ticks mark the sys_clk edge on which sclk_o toggles.
  assign rise_o = wrap && !sclk_o;
  assign fall_o = wrap && sclk_o;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt <= '0;
      sclk_o  <= SCLK_IDLE;
    end else if (!en_i) begin
      div_cnt <= '0;
      sclk_o  <= SCLK_IDLE;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk_o  <= ~sclk_o;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/spi_master_burst.sv
// spi_master_burst: mode-0 SPI master, instruction word + 1..MAX_BYTES burst.
// Ports: start_i/cmd_i/wdata_i -> ready_o/done_o/rdata_o; SCLK_O/CS_O/MOSI_O/MISO_I pins.
module spi_master_burst
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int CMD_W     = 16,
  parameter int MAX_BYTES = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic                   sys_clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic [CMD_W-1:0]       cmd_i,
  input  logic [8*MAX_BYTES-1:0] wdata_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic [8*MAX_BYTES-1:0] rdata_o,
  output logic                   SCLK_O,
  output logic                   CS_O,
  output logic                   MOSI_O,
  input  logic                   MISO_I
);

  localparam int DW   = 8 * MAX_BYTES;
  localparam int TW   = CMD_W + DW;
  localparam int BW   = $clog2(TW + 1);
  localparam int CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW   = $clog2(CMAX + 1);

  state_e state, state_d;

  logic [CW-1:0] cyc_cnt;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] last_q;
  logic [TW-1:0] sh;
  logic [DW-1:0] rx;
  logic          rnw_q;

  logic          sclk_en;
  logic          rise;
  logic          fall;

  logic          accept;
  logic          to_cmd;
  logic          to_hold;
  logic          finish;

  int            nb;
  logic          rnw_w;
  logic [DW-1:0] tx_al;

  // Write bytes are the low nb bytes of wdata_i; left-align them
  // so the shifter sends them straight after the instruction.
  always_comb begin
    nb    = nbytes_f(cmd_i[CMD_W-WCNT_OFS -: 2], MAX_BYTES);
    rnw_w = cmd_i[CMD_W-RNW_OFS];
    tx_al = '0;
    if (!rnw_w) tx_al = wdata_i << (8 * (MAX_BYTES - nb));
  end

  assign sclk_en = (state == ST_CMD) || (state == ST_DATA);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .sys_clk_i (sys_clk_i),
    .rst_n_i   (rst_n_i),
    .en_i      (sclk_en),
    .sclk_o    (SCLK_O),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    to_cmd  = 1'b0;
    to_hold = 1'b0;
    finish  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_i && ready_o) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cyc_cnt == CW'(CS_SETUP - 1)) begin
          to_cmd  = 1'b1;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (fall && bit_cnt == BW'(CMD_W - 1))
          state_d = ST_DATA;
      end
      ST_DATA: begin
        if (fall && bit_cnt == last_q) begin
          to_hold = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cyc_cnt == CW'(CS_HOLD - 1)) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_cnt <= '0;
      bit_cnt <= '0;
      last_q  <= '0;
      sh      <= '0;
      rx      <= '0;
      rnw_q   <= 1'b0;
      CS_O    <= CS_IDLE;
      MOSI_O  <= MOSI_IDLE;
      ready_o <= 1'b1;
      done_o  <= 1'b0;
      rdata_o <= '0;
    end else begin
      done_o <= 1'b0;

      if (state == ST_SETUP || state == ST_HOLD)
        cyc_cnt <= cyc_cnt + CW'(1);
      else
        cyc_cnt <= '0;

      if (accept) begin
        sh      <= {cmd_i, tx_al};
        rx      <= '0;
        rnw_q   <= rnw_w;
        last_q  <= BW'(CMD_W + 8 * nb - 1);
        bit_cnt <= '0;
        ready_o <= 1'b0;
        CS_O    <= ~CS_IDLE;
      end

      if (to_cmd) MOSI_O <= sh[TW-1];

      // MOSI only moves at the start of a low half; after the
      // last bit it holds until CS_O is released.
      if (fall) begin
        bit_cnt <= bit_cnt + BW'(1);
        sh      <= sh << 1;
        if (!to_hold) MOSI_O <= sh[TW-2];
      end

      if (rise && state == ST_DATA && rnw_q)
        rx <= {rx[DW-2:0], MISO_I};

      if (finish) begin
        CS_O    <= CS_IDLE;
        MOSI_O  <= MOSI_IDLE;
        ready_o <= 1'b1;
        done_o  <= 1'b1;
        if (rnw_q) rdata_o <= rx;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_burst.sv
// tb_spi_master_burst: directed checks of the burst SPI master.
// Two instances: CLK_DIV=2 (main) and CLK_DIV=1 (fast divider).
module tb_spi_master_burst;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic [15:0] cmd = '0;
  logic [31:0] wdata = '0;
  logic        miso;

  logic        ready, done, sclk, cs, mosi;
  logic [31:0] rdata;
  logic        ready1, done1, sclk1, cs1, mosi1;
  logic [31:0] rdata1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_master_burst #(
    .CLK_DIV(2), .CMD_W(16), .MAX_BYTES(4),
    .CS_SETUP(2), .CS_HOLD(2)
  ) u_dut (
    .sys_clk_i (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .cmd_i     (cmd),
    .wdata_i   (wdata),
    .ready_o   (ready),
    .done_o    (done),
    .rdata_o   (rdata),
    .SCLK_O    (sclk),
    .CS_O      (cs),
    .MOSI_O    (mosi),
    .MISO_I    (miso)
  );

  spi_master_burst #(
    .CLK_DIV(1), .CMD_W(16), .MAX_BYTES(4),
    .CS_SETUP(2), .CS_HOLD(2)
  ) u_dut1 (
    .sys_clk_i (clk),
    .rst_n_i   (rst_n),
    .start_i   (start1),
    .cmd_i     (cmd),
    .wdata_i   (wdata),
    .ready_o   (ready1),
    .done_o    (done1),
    .rdata_o   (rdata1),
    .SCLK_O    (sclk1),
    .CS_O      (cs1),
    .MOSI_O    (mosi1),
    .MISO_I    (miso)
  );

  // Slave side: MOSI captured on SCLK rise, MISO advanced on SCLK fall.
  logic [63:0] cap = '0;
  logic [63:0] cap1 = '0;
  int          pulses = 0;
  int          pulses1 = 0;
  int          fidx = 0;
  logic        sclk_seen = 1'b0;
  logic [39:0] frame = '0;

  assign miso = (fidx < 40) ? frame[6'(39 - fidx)] : 1'b0;

  always @(posedge sclk or negedge sclk or negedge cs) begin
    if (sclk !== sclk_seen) begin
      if (sclk) begin
        cap = {cap[62:0], mosi};
        pulses++;
      end else begin
        fidx++;
      end
      sclk_seen = sclk;
    end else if (!cs) begin
      cap    = '0;
      pulses = 0;
      fidx   = 0;
    end
  end

  always @(posedge sclk1 or negedge cs1) begin
    if (sclk1) begin
      cap1 = {cap1[62:0], mosi1};
      pulses1++;
    end else if (!cs1) begin
      cap1    = '0;
      pulses1 = 0;
    end
  end

  // CS low length, CS high gap before each transaction, done counts.
  logic cs_prev = 1'b1;
  logic cs_prev1 = 1'b1;
  int   lo_cnt = 0, hi_cnt = 0, gap_q = 0, dn = 0;
  int   lo_cnt1 = 0, dn1 = 0;

  always @(posedge clk) begin
    if (cs) begin
      hi_cnt <= cs_prev ? hi_cnt + 1 : 1;
    end else begin
      lo_cnt <= cs_prev ? 1 : lo_cnt + 1;
      if (cs_prev) gap_q <= hi_cnt;
    end
    cs_prev <= cs;
    if (done) dn <= dn + 1;
    if (!cs1) lo_cnt1 <= cs_prev1 ? 1 : lo_cnt1 + 1;
    cs_prev1 <= cs1;
    if (done1) dn1 <= dn1 + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [15:0] c, input logic [31:0] w);
    @(negedge clk);
    cmd   = c;
    wdata = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int lim);
    int n;
    n = 0;
    while (((which ? done1 : done) !== 1'b1) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(which ? "done1_seen" : "done_seen",
        which ? done1 : done, 1'b1);
  endtask

  int d0, d1, n;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cs", cs, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_rdata", rdata, 32'h0);

    // single-byte write
    d0 = dn;
    go(16'h0010, 32'h0000_0099);
    chk("acc_ready", ready, 1'b0);
    chk("acc_cs", cs, 1'b0);
    wait_done(1'b0, 200);
    chk("wr_end_ready", ready, 1'b1);
    chk("wr_end_cs", cs, 1'b1);
    chk("wr_pulses", pulses, 24);
    chk("wr_mosi", cap[23:0], 24'h001099);
    chk("wr_cs_len", lo_cnt, 100);
    chk("wr_rdata", rdata, 32'h0);
    @(negedge clk);
    chk("wr_done_low", done, 1'b0);
    chk("wr_done_cnt", dn - d0, 1);

    // two-byte read with a stray start mid-transfer
    frame = {16'hFFFF, 8'h5A, 8'hC3, 8'h00};
    d0 = dn;
    go(16'hA232, 32'hDEAD_BEEF);
    repeat (20) @(negedge clk);
    cmd   = 16'h0010;
    wdata = 32'h99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 300);
    chk("rd_rdata", rdata, 32'h0000_5AC3);
    chk("rd_pulses", pulses, 32);
    chk("rd_mosi", cap[31:0], 32'hA232_0000);
    chk("rd_cs_len", lo_cnt, 132);
    repeat (4) @(negedge clk);
    chk("ign_cs", cs, 1'b1);
    chk("ign_ready", ready, 1'b1);
    chk("ign_done_cnt", dn - d0, 1);

    // CLK_DIV=1, W1:W0=11 four-byte write
    d1 = dn1;
    @(negedge clk);
    cmd    = 16'h6000;
    wdata  = 32'h1122_3344;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b1, 200);
    chk("d1_pulses", pulses1, 48);
    chk("d1_mosi", cap1[47:0], 48'h6000_1122_3344);
    chk("d1_cs_len", lo_cnt1, 100);
    chk("d1_rdata", rdata1, 32'h0);
    @(negedge clk);
    chk("d1_done_cnt", dn1 - d1, 1);

    // async reset during command bit 10
    d0 = dn;
    go(16'h0010, 32'h0000_0099);
    n = 0;
    while (pulses < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_bit10", pulses, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_cs", cs, 1'b1);
    chk("mid_sclk", sclk, 1'b0);
    chk("mid_ready", ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_no_done", dn - d0, 0);
    chk("mid_rdata", rdata, 32'h0);

    go(16'h0010, 32'h0000_0099);
    wait_done(1'b0, 200);
    chk("post_pulses", pulses, 24);
    chk("post_mosi", cap[23:0], 24'h001099);
    chk("post_cs_len", lo_cnt, 100);

    // back-to-back: start held through the done cycle
    repeat (3) @(negedge clk);
    d0 = dn;
    cmd   = 16'h0010;
    wdata = 32'h99;
    start = 1'b1;
    @(negedge clk);
    wait_done(1'b0, 200);
    cmd = 16'h8000;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_cs", cs, 1'b0);
    chk("b2b_ready", ready, 1'b0);
    wait_done(1'b0, 200);
    chk("b2b_gap", gap_q, 1);
    chk("b2b_cs_len", lo_cnt, 100);
    chk("b2b_mosi", cap[23:0], 24'h800000);
    chk("b2b_rdata", rdata, 32'h0000_005A);
    @(negedge clk);
    chk("b2b_done_cnt", dn - d0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
